fp_add_result_collector: RTL and testbench

- Receiving end of the pipelined floating-point adder's output.
- Tracks each operand pair issued with valid and enable through a tag pipeline that matches the adder's latency, then captures each result exactly once.
- Classifies each captured result as zero, inf, NaN or denormal, and buffers it in a show-ahead FIFO with a ready/valid output.
- Returns credit upstream through issue_ready so that accepted issues never overflow the FIFO.

---
 rtl/fp_add_result_collector.sv | 142 ++++++++++++++
 tb/tb_fp_add_result_collector.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_result_collector.sv
// Collects results from the pipelined FP adder: tracks issues through a tag pipeline
// matching the adder latency, classifies each result and buffers it in a show-ahead FIFO.
module fp_add_result_collector #(
  parameter int FP_SIZE     = 32,
  parameter int EXP_SIZE    = 8,
  parameter int FRAC_SIZE   = 23,
  parameter int PIPE_STAGES = 3,
  parameter int DEPTH       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         valid,
  input  logic [FP_SIZE-1:0]           result_in,
  output logic                         issue_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FP_SIZE-1:0]           out_data,
  output logic                         out_zero,
  output logic                         out_inf,
  output logic                         out_nan,
  output logic                         out_denorm,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(DEPTH + PIPE_STAGES + 2) + 1;

  logic [PIPE_STAGES-1:0] tags;
  logic                   tf;
  logic                   en_q;

  logic [FP_SIZE-1:0]     mem_data  [DEPTH];
  logic [3:0]             mem_flags [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [FP_SIZE-1:0]     last_data;
  logic [3:0]             last_flags;

  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   do_write;
  logic [EXP_SIZE-1:0]    exp_f;
  logic [FRAC_SIZE-1:0]   frac_f;
  logic [3:0]             flags_in;
  logic [SW-1:0]          inflight;
  logic [3:0]             head_flags;

  // tf mirrors the adder's ungated output register: it is only set on the cycle
  // after the last enabled bank actually advanced, so stalls never re-push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tags <= '0;
      tf   <= 1'b0;
      en_q <= 1'b0;
    end else begin
      en_q <= enable;
      tf   <= tags[PIPE_STAGES-1] & en_q;
      if (enable) begin
        tags[0] <= valid;
        for (int unsigned i = 1; i < PIPE_STAGES; i++)
          tags[i] <= tags[i-1];
      end
    end
  end

  always_comb begin
    exp_f    = result_in[FP_SIZE-2 -: EXP_SIZE];
    frac_f   = result_in[FRAC_SIZE-1:0];
    flags_in = '0;
    flags_in[3] = (exp_f == '0) && (frac_f == '0);
    flags_in[2] = (exp_f == '1) && (frac_f == '0);
    flags_in[1] = (exp_f == '1) && (frac_f != '0);
    flags_in[0] = (exp_f == '0) && (frac_f != '0);
  end

  assign push     = tf;
  assign out_valid = (count != '0);
  assign pop      = out_valid & out_ready;
  assign full     = (count == CW'(DEPTH));
  assign do_write = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_data[wr_ptr]  <= result_in;
      mem_flags[wr_ptr] <= flags_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      last_data  <= '0;
      last_flags <= '0;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        last_data  <= mem_data[rd_ptr];
        last_flags <= mem_flags[rd_ptr];
      end
      if (push & full & ~pop)
        overflow <= 1'b1;
      if (do_write & ~pop)
        count <= count + 1'b1;
      else if (pop & ~do_write)
        count <= count - 1'b1;
    end
  end

  // An empty FIFO keeps presenting the most recently popped entry.
  always_comb begin
    if (out_valid) begin
      out_data   = mem_data[rd_ptr];
      head_flags = mem_flags[rd_ptr];
    end else begin
      out_data   = last_data;
      head_flags = last_flags;
    end
  end

  assign out_zero   = head_flags[3];
  assign out_inf    = head_flags[2];
  assign out_nan    = head_flags[1];
  assign out_denorm = head_flags[0];

  always_comb begin
    inflight = SW'(tf);
    for (int unsigned i = 0; i < PIPE_STAGES; i++)
      inflight = inflight + SW'(tags[i]);
  end

  assign issue_ready = (SW'(count) + inflight) < SW'(DEPTH);

endmodule

// File: tb/tb_fp_add_result_collector.sv
// Scoreboard bench for fp_add_result_collector with a behavioural adder model driving result_in.
module tb_fp_add_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        valid;
  logic [31:0] result_in;
  logic        issue_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_zero, out_inf, out_nan, out_denorm;
  logic [3:0]  count;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  logic [31:0] din = '0;
  logic [31:0] b1 = '0, b2 = '0, b3 = '0;

  fp_add_result_collector #(
    .FP_SIZE(32), .EXP_SIZE(8), .FRAC_SIZE(23), .PIPE_STAGES(3), .DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .valid(valid), .result_in(result_in),
    .issue_ready(issue_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_inf(out_inf), .out_nan(out_nan),
    .out_denorm(out_denorm), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Adder stand-in: three enable-gated banks carrying the precomputed sum, then an ungated output register.
  always @(posedge clk) begin
    if (enable) begin
      b1 <= din;
      b2 <= b1;
      b3 <= b2;
    end
    result_in <= b3;
  end

  function automatic logic [3:0] classify(input logic [31:0] v);
    logic [7:0]  e;
    logic [22:0] f;
    e = v[30:23];
    f = v[22:0];
    return {e == 8'h00 && f == 0, e == 8'hFF && f == 0, e == 8'hFF && f != 0, e == 8'h00 && f != 0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every accepted head must match the oldest outstanding issue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pop: got 0x%08h expected none", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_data", out_data, e);
        chk("pop_flags", {28'd0, out_zero, out_inf, out_nan, out_denorm}, {28'd0, classify(e)});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] r);
    valid = 1'b1;
    din   = r;
    if (enable) exp_q.push_back(r);
    step();
    valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((count != 0 || exp_q.size() != 0) && n < 40) begin
      step();
      n++;
    end
    chk("drain_done", {28'd0, count}, 32'd0);
    chk("drain_queue", exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int issued;
    rst = 1'b1; enable = 1'b1; valid = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flags", {28'd0, out_zero, out_inf, out_nan, out_denorm}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_issue_ready", {31'd0, issue_ready}, 32'd1);

    // single issue: push lands on the 5th edge counting the issue edge as the 1st
    issue(32'h40000000);
    repeat (3) step();
    chk("single_edge4_count", {28'd0, count}, 32'd0);
    step();
    chk("single_edge5_count", {28'd0, count}, 32'd1);
    chk("single_out_valid", {31'd0, out_valid}, 32'd1);
    chk("single_out_data", out_data, 32'h40000000);
    drain();
    chk("hold_last_data", out_data, 32'h40000000);
    chk("hold_out_valid", {31'd0, out_valid}, 32'd0);

    // back-to-back with consumer stalled
    valid = 1'b1;
    din = 32'h40000000; exp_q.push_back(din); step();
    din = 32'h40800000; exp_q.push_back(din); step();
    din = 32'h40400000; exp_q.push_back(din); step();
    valid = 1'b0;
    repeat (5) step();
    chk("b2b_count", {28'd0, count}, 32'd3);
    chk("b2b_head", out_data, 32'h40000000);
    drain();

    // stall after 2nd edge for 3 cycles: push 3 edges late
    issue(32'h3FC00000);
    step();
    enable = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    step(); step();
    chk("stall_edge7_count", {28'd0, count}, 32'd0);
    step();
    chk("stall_edge8_count", {28'd0, count}, 32'd1);
    repeat (6) step();
    chk("stall_no_dup", {28'd0, count}, 32'd1);
    drain();

    // 2-cycle stall once tag reaches t3: one push, no duplicate
    issue(32'h41200000);
    step(); step();
    enable = 1'b0;
    step(); step();
    chk("stall3_count", {28'd0, count}, 32'd1);
    enable = 1'b1;
    repeat (6) step();
    chk("stall3_no_dup", {28'd0, count}, 32'd1);
    drain();

    // classification
    issue(32'h80000000);
    issue(32'h7F800000);
    issue(32'h7FC00000);
    issue(32'h00000001);
    repeat (6) step();
    chk("flags_count", {28'd0, count}, 32'd4);
    chk("flags_head_zero", {28'd0, out_zero, out_inf, out_nan, out_denorm}, 32'h8);
    drain();

    // credit: fill to DEPTH with consumer stalled
    issued = 0;
    for (int i = 0; i < 30; i++) begin
      if (!issue_ready) break;
      issue($urandom());
      issued++;
    end
    chk("credit_issued", issued, 8);
    repeat (8) step();
    chk("credit_count", {28'd0, count}, 32'd8);
    chk("credit_overflow", {31'd0, overflow}, 32'd0);
    chk("credit_ready_low", {31'd0, issue_ready}, 32'd0);
    valid = 1'b1; din = 32'hDEADBEEF; step(); valid = 1'b0;
    repeat (8) step();
    chk("forced_overflow", {31'd0, overflow}, 32'd1);
    chk("forced_count", {28'd0, count}, 32'd8);
    drain();

    // reset mid-operation
    issue(32'h3F800000); issue(32'h40000000); issue(32'h40400000);
    repeat (5) step();
    chk("pre_rst_count", {28'd0, count}, 32'd3);
    issue(32'h40800000); issue(32'h40A00000);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_count", {28'd0, count}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    step();
    rst = 1'b0;
    repeat (8) step();
    chk("post_rst_no_push", {28'd0, count}, 32'd0);

    // randomized traffic honouring issue_ready
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      enable    = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: r = 32'h00000000;
        1: r = 32'hFF800000;
        2: r = 32'hFFC00001;
        3: r = 32'h807FFFFF;
        default: r = $urandom();
      endcase
      valid = issue_ready && ($urandom_range(0, 1) == 1);
      din   = r;
      if (valid && enable) exp_q.push_back(r);
      step();
    end
    valid = 1'b0;
    enable = 1'b1;
    repeat (6) step();
    drain();
    chk("random_overflow", {31'd0, overflow}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
